online_digit_frame_ctrl: RTL and testbench
==========================================

// Module: online_digit_frame_ctrl
// PURPOSE
//  Parametrised MSD-first digit-serial frame controller for online (radix-2^k signed-digit) arithmetic units.
//  Accepts parallel operand pairs over valid/ready, streams digits MSD-first to an online unit with online delay DELTA,
//  gathers result digits into a parallel word (truncated or full-length, per frame), returns it over valid/ready.
//  Sits between parallel datapath/bench logic and any serial online operator (multiplier, adder).
// PARAMETERS
//  NUM_DIGITS  4  operand length in digits
//  DIGIT_BITS  3  bits per signed digit (opaque to this block)
//  DELTA       2  online delay of attached unit, cycles (>=0)
//  GAP         2  zero-digit flush cycles after each frame (>=0)
// PORTS
//  clk        in   1                      clock, rising edge
//  rst_n      in   1                      asynchronous active-low reset
//  in_valid   in   1                      operand pair valid
//  in_ready   out  1                      block can accept operands
//  in_x       in   NUM_DIGITS*DIGIT_BITS  operand X, MS digit in top DIGIT_BITS
//  in_y       in   NUM_DIGITS*DIGIT_BITS  operand Y, same layout
//  in_full    in   1                      1: collect 2*NUM_DIGITS result digits; 0: NUM_DIGITS
//  frame_start out 1                      high in frame cycle 0 only (unit state clear)
//  x_dig      out  DIGIT_BITS             X digit to unit
//  y_dig      out  DIGIT_BITS             Y digit to unit
//  z_dig      in   DIGIT_BITS             result digit from unit
//  res_valid  out  1                      result word valid
//  res_ready  in   1                      consumer takes result
//  res_data   out  2*NUM_DIGITS*DIGIT_BITS result, first-captured digit in top DIGIT_BITS
//  res_full   out  1                      in_full captured for this frame
//  busy       out  1                      state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, shift regs, res_data, res_full, counter = 0; in_ready=1, all other outputs 0.
//  - States: IDLE -> FEED -> DRAIN -> FLUSH -> HOLD -> IDLE. in_ready = (state==IDLE).
//  - Accept on edge with in_valid&&in_ready (edge E0): load in_x/in_y into shift regs, latch in_full,
//    clear res_data, cnt=0, go FEED. Frame cycle k spans edges E_k..E_k+1.
//  - NOUT = in_full ? 2*NUM_DIGITS : NUM_DIGITS (latched). FRAME = DELTA+NOUT cycles.
//  - x_dig/y_dig: combinational from shift-reg top digit in FEED (cycles 0..NUM_DIGITS-1), shift by DIGIT_BITS per edge;
//    forced 0 in every other state. frame_start = (state==FEED && cnt==0).
//  - DRAIN covers cycles NUM_DIGITS..FRAME-1 (zero digits); if FRAME<=NUM_DIGITS capture still runs in FEED.
//  - Capture: at end of cycle k, DELTA<=k<FRAME, res_data <= {res_data[..], z_dig} shifted in at LSB;
//    after capture end, truncated word is left-justified (shift by NUM_DIGITS*DIGIT_BITS), lower half 0.
//  - After cycle FRAME-1: FLUSH for GAP cycles (digits 0; GAP=0 skips), then HOLD with res_valid=1.
//    res_valid rises at edge E_{FRAME+GAP}; registered, so res_ready sampled only while res_valid=1.
//  - HOLD: res_data/res_full stable until res_valid&&res_ready; then IDLE, in_ready=1 next cycle (no bypass).
//  - in_valid while busy: ignored, not queued. in_x/in_y/in_full changes after E0: no effect.
//  - z_dig ignored outside capture window; unit X/Z on z_dig outside window must not propagate.
//  - Async reset mid-frame: immediate abort to IDLE, partial result discarded, res_valid=0.
//  - cnt width clog2(DELTA+2*NUM_DIGITS+GAP+1); no wrap within a frame.
// TESTING (N=4, B=3, DELTA=2, GAP=2; bench unit model: z_dig = x_dig delayed DELTA cycles)
//  1 Reset: rst_n=0 mid-run -> in_ready=1, res_valid=0, x_dig=y_dig=0, busy=0 immediately.
//  2 Truncated: in_x=001_010_011_111, in_full=0 -> x_dig 001,010,011,111 cycles 0-3; res_valid at E8;
//    res_data = 001_010_011_111_000_000_000_000, res_full=0.
//  3 Full: same in_x, in_full=1 -> res_valid at E12; res_data = 001_010_011_111_000_000_000_000... zeros digits 4-7, res_full=1.
//  4 Backpressure: res_ready=0 for 5 cycles in HOLD -> res_data stable, in_ready=0, new in_valid ignored; then res_ready=1 -> IDLE.
//  5 Back-to-back: in_valid held high, res_ready=1 -> accepts every FRAME+GAP+2 cycles, frame_start one-cycle pulses, no digit loss.
//  6 Abort: rst_n low during cycle 3 of frame, release, new operand 111_111_111_111 -> clean result, no stale digits.

Source files
------------

// File: rtl/online_digit_frame_ctrl.sv
// online_digit_frame_ctrl
//   MSD-first digit-serial frame controller for an attached online (signed-digit) unit.
//   Takes a parallel operand pair over valid/ready, streams digits MSD-first to the unit,
//   collects NUM_DIGITS or 2*NUM_DIGITS result digits after the unit's online delay, flushes
//   GAP zero-digit cycles, then presents the collected word over valid/ready.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready is high only while idle
//   in_x, in_y            operands, most significant digit in the top DIGIT_BITS
//   in_full               1: collect 2*NUM_DIGITS result digits, 0: NUM_DIGITS
//   frame_start           high in frame cycle 0 only (clears unit state)
//   x_dig, y_dig          digits to the unit, zero outside the feed phase
//   z_dig                 result digit from the unit, used only inside the capture window
//   res_valid/res_ready   result handshake
//   res_data              result word, first captured digit in the top DIGIT_BITS
//   res_full              in_full value latched for this frame
//   busy                  controller is not idle

module online_digit_frame_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_BITS = 3,
    parameter int unsigned DELTA      = 2,
    parameter int unsigned GAP        = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0]   in_x,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0]   in_y,
    input  logic                               in_full,
    output logic                               frame_start,
    output logic [DIGIT_BITS-1:0]              x_dig,
    output logic [DIGIT_BITS-1:0]              y_dig,
    input  logic [DIGIT_BITS-1:0]              z_dig,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [2*NUM_DIGITS*DIGIT_BITS-1:0] res_data,
    output logic                               res_full,
    output logic                               busy
);

    localparam int unsigned OpW  = NUM_DIGITS * DIGIT_BITS;
    localparam int unsigned ResW = 2 * OpW;
    localparam int unsigned CntW = $clog2(DELTA + 2 * NUM_DIGITS + GAP + 1);

    typedef enum logic [2:0] {StIdle, StFeed, StDrain, StFlush, StHold} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [OpW-1:0]    x_sr_q, x_sr_d;
    logic [OpW-1:0]    y_sr_q, y_sr_d;
    logic [ResW-1:0]   res_data_q, res_data_d;
    logic              res_full_q, res_full_d;
    logic              res_valid_q, res_valid_d;

    logic [CntW-1:0]   frame_len;
    logic              feed_last;
    logic              frame_last;
    logic              flush_last;
    logic              capture;
    logic [ResW-1:0]   shifted;

    // Frame length depends on the result length latched at accept time.
    assign frame_len  = res_full_q ? CntW'(DELTA + 2 * NUM_DIGITS) : CntW'(DELTA + NUM_DIGITS);
    assign feed_last  = (cnt_q == CntW'(NUM_DIGITS - 1));
    assign frame_last = (cnt_q == frame_len - CntW'(1));
    assign flush_last = (cnt_q == frame_len + CntW'(GAP) - CntW'(1));
    // Capture can start while still feeding when DELTA < NUM_DIGITS.
    assign capture    = ((state_q == StFeed) || (state_q == StDrain)) && (cnt_q >= CntW'(DELTA));
    assign shifted    = {res_data_q[ResW-DIGIT_BITS-1:0], z_dig};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_sr_d      = x_sr_q;
        y_sr_d      = y_sr_q;
        res_data_d  = res_data_q;
        res_full_d  = res_full_q;
        res_valid_d = res_valid_q;

        if (capture) begin
            // A truncated result ends up in the lower half; left-justify it on the last digit.
            if (frame_last && !res_full_q) begin
                res_data_d = {shifted[OpW-1:0], {OpW{1'b0}}};
            end else begin
                res_data_d = shifted;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d    = StFeed;
                    cnt_d      = '0;
                    x_sr_d     = in_x;
                    y_sr_d     = in_y;
                    res_full_d = in_full;
                    res_data_d = '0;
                end
            end
            StFeed, StDrain: begin
                cnt_d = cnt_q + CntW'(1);
                if (state_q == StFeed) begin
                    x_sr_d = x_sr_q << DIGIT_BITS;
                    y_sr_d = y_sr_q << DIGIT_BITS;
                end
                if (frame_last) begin
                    if (GAP == 0) begin
                        state_d     = StHold;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = StFlush;
                    end
                end else if ((state_q == StFeed) && feed_last) begin
                    state_d = StDrain;
                end
            end
            StFlush: begin
                cnt_d = cnt_q + CntW'(1);
                if (flush_last) begin
                    state_d     = StHold;
                    res_valid_d = 1'b1;
                end
            end
            StHold: begin
                if (res_ready) begin
                    state_d     = StIdle;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            x_sr_q      <= '0;
            y_sr_q      <= '0;
            res_data_q  <= '0;
            res_full_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_sr_q      <= x_sr_d;
            y_sr_q      <= y_sr_d;
            res_data_q  <= res_data_d;
            res_full_q  <= res_full_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign frame_start = (state_q == StFeed) && (cnt_q == '0);
    assign x_dig       = (state_q == StFeed) ? x_sr_q[OpW-1 -: DIGIT_BITS] : '0;
    assign y_dig       = (state_q == StFeed) ? y_sr_q[OpW-1 -: DIGIT_BITS] : '0;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_full    = res_full_q;

endmodule

// File: tb/tb_online_digit_frame_ctrl.sv
// Bench for online_digit_frame_ctrl with an echo unit model: z_dig is x_dig delayed DELTA
// cycles inside the capture window and a junk pattern everywhere else.
module tb_online_digit_frame_ctrl;

    localparam int N     = 4;
    localparam int B     = 3;
    localparam int DELTA = 2;
    localparam int GAP   = 2;
    localparam int OW    = N * B;
    localparam int RW    = 2 * OW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] in_x = '0;
    logic [OW-1:0] in_y = '0;
    logic          in_full = 1'b0;
    logic          frame_start;
    logic [B-1:0]  x_dig, y_dig, z_dig;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          res_full;
    logic          busy;

    online_digit_frame_ctrl #(
        .NUM_DIGITS(N), .DIGIT_BITS(B), .DELTA(DELTA), .GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_full(in_full), .frame_start(frame_start),
        .x_dig(x_dig), .y_dig(y_dig), .z_dig(z_dig), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_full(res_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- unit model and scoreboard ----------------
    typedef struct {
        logic [RW-1:0] data;
        logic          full;
        int            lat;
        int            acc_t;
    } exp_t;
    exp_t sb[$];

    int            tcyc = 0;
    int            last_acc_t = -100;
    int            last_lat = 0;
    logic [OW-1:0] cur_x = '0;
    logic [OW-1:0] cur_y = '0;
    logic          cur_full = 1'b0;
    logic [B-1:0]  d1 = '0, d2 = '0;
    int            n_acc = 0;
    int            n_fs = 0;
    int            rise_t = 0;
    bit            rv_seen = 0;
    bit            b2b = 0;
    int            b2b_cnt = 0;
    int            fk;
    int            flen;

    assign fk    = tcyc - last_acc_t;
    assign flen  = DELTA + (cur_full ? 2 * N : N);
    assign z_dig = (fk >= DELTA && fk < flen) ? d2 : 3'b101;

    always @(posedge clk) begin
        tcyc <= tcyc + 1;
        d1   <= x_dig;
        d2   <= d1;
    end

    // Accept monitor: push the expected result when an operand pair is taken.
    always @(posedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            e.data  = {in_x, {OW{1'b0}}};
            e.full  = in_full;
            e.lat   = DELTA + (in_full ? 2 * N : N) + GAP;
            e.acc_t = tcyc + 1;
            sb.push_back(e);
            if (b2b && b2b_cnt > 0) check("b2b_spacing", tcyc + 1 - last_acc_t, last_lat + 2);
            if (b2b) b2b_cnt++;
            last_lat   <= e.lat;
            last_acc_t <= tcyc + 1;
            cur_x      <= in_x;
            cur_y      <= in_y;
            cur_full   <= in_full;
            n_acc++;
        end
    end

    // Result monitor: pop and compare on each handshake.
    always @(posedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_res_data", res_data, e.data);
                check("sb_res_full", res_full, e.full);
                check("sb_latency", rise_t - e.acc_t, e.lat);
            end
            rv_seen = 0;
        end
    end

    // Digit / frame_start monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("frame_start", frame_start, busy && fk == 0);
            if (frame_start) n_fs++;
            if (busy && fk >= 0 && fk < N) begin
                check("x_dig", x_dig, cur_x[(N - 1 - fk) * B +: B]);
                check("y_dig", y_dig, cur_y[(N - 1 - fk) * B +: B]);
            end else begin
                check("x_dig_zero", x_dig, 0);
                check("y_dig_zero", y_dig, 0);
            end
            if (res_valid && !rv_seen) begin
                rise_t  = tcyc;
                rv_seen = 1;
            end
        end
    end

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [OW-1:0] x;
        logic [OW-1:0] y;
        logic          full;
        int            hold;
        logic [RW-1:0] exp_data;
    } vec_t;
    vec_t vecs[5];

    task automatic run_vec(input int i);
        vec_t v;
        logic [RW-1:0] held;
        int t;
        v = vecs[i];
        @(negedge clk);
        in_x = v.x; in_y = v.y; in_full = v.full; in_valid = 1'b1;
        res_ready = (v.hold == 0);
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        check("accept_timeout", t < 50, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_x = ~v.x; in_y = ~v.y; in_full = ~v.full;
        t = 0;
        while (!res_valid && t < 50) begin @(negedge clk); t++; end
        check("res_valid_timeout", t < 50, 1);
        check("vec_res_data", res_data, v.exp_data);
        check("vec_res_full", res_full, v.full);
        held = res_data;
        if (v.hold > 0) begin
            in_valid = 1'b1; in_x = OW'($urandom);
            repeat (v.hold) begin
                @(negedge clk);
                check("hold_in_ready", in_ready, 0);
                check("hold_res_valid", res_valid, 1);
                check("hold_res_data", res_data, held);
            end
            in_valid  = 1'b0;
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_hs_res_valid", res_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        res_ready = 1'b0;
    endtask

    logic [OW-1:0] b2b_x[4];

    initial begin
        int t;
        vecs[0] = '{12'b001_010_011_111, 12'b111_000_101_010, 1'b0, 0,
                    24'b001_010_011_111_000_000_000_000};
        vecs[1] = '{12'b001_010_011_111, 12'b010_011_100_101, 1'b1, 0,
                    24'b001_010_011_111_000_000_000_000};
        vecs[2] = '{12'b110_101_100_011, 12'b001_001_001_001, 1'b0, 5,
                    24'b110_101_100_011_000_000_000_000};
        vecs[3] = '{12'b011_100_001_110, 12'b100_100_000_111, 1'b1, 3,
                    24'b011_100_001_110_000_000_000_000};
        vecs[4] = '{12'b111_111_111_111, 12'b111_111_111_111, 1'b0, 0,
                    24'b111_111_111_111_000_000_000_000};
        b2b_x[0] = 12'b101_011_110_001;
        b2b_x[1] = 12'b010_111_001_100;
        b2b_x[2] = 12'b100_001_111_010;
        b2b_x[3] = 12'b000_000_000_000;

        // Reset state
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_x_dig", x_dig, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_full", res_full, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Back-to-back frames with in_valid and res_ready held high
        @(negedge clk);
        b2b = 1; res_ready = 1'b1; in_valid = 1'b1; in_x = b2b_x[0]; in_full = 1'b0;
        for (int j = 0; j < 3; j++) begin
            t = 0;
            while (!in_ready && t < 100) begin @(negedge clk); t++; end
            check("b2b_accept_timeout", t < 100, 1);
            @(posedge clk);
            #1;
            in_x = b2b_x[j + 1]; in_y = ~b2b_x[j + 1]; in_full = (j == 0);
            if (j == 2) in_valid = 1'b0;
            @(negedge clk);
        end
        t = 0;
        while ((busy || sb.size() != 0) && t < 100) begin @(negedge clk); t++; end
        check("b2b_drain_timeout", t < 100, 1);
        b2b = 0; res_ready = 1'b0;

        // Abort mid-frame, then a clean frame
        @(negedge clk);
        in_x = 12'b010_110_001_011; in_y = 12'b011_011_011_011; in_full = 1'b1; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_res_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_x_dig", x_dig, 0);
        check("abort_y_dig", y_dig, 0);
        sb.delete();
        rv_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(4);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("frame_start_count", n_fs, n_acc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
